wb_stream_fetcher: RTL

WB_STREAM_FETCHER -- requirements
Module: wb_stream_fetcher

---
 rtl/wb_stream_fetcher.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/wb_stream_fetcher.sv
// Wishbone burst-read fetcher: streams a memory buffer through a FWFT FIFO,
// configured and monitored through a small Wishbone register slave.
//
// state   | meaning
// IDLE    | no transfer in progress; waiting for a start strobe
// WAIT    | words remain; waiting until the FIFO can absorb the next burst
// BURST   | bus cycle active; one FIFO push per acknowledged beat
module wb_stream_fetcher #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 5,
    parameter int MAX_BURST_LEN = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic [WB_AW-1:0]     wbs_adr_i,
    input  logic [WB_DW-1:0]     wbs_dat_i,
    input  logic [WB_DW/8-1:0]   wbs_sel_i,
    input  logic                 wbs_we_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    output logic [WB_DW-1:0]     wbs_dat_o,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o,
    output logic [WB_DW-1:0]     stream_m_data_o,
    output logic                 stream_m_valid_o,
    input  logic                 stream_m_ready_i,
    output logic                 irq_o
);

    localparam int WSB    = WB_DW / 8;
    localparam int WSB_LG = (WSB > 1) ? $clog2(WSB) : 0;
    localparam int DEPTH  = 2 ** FIFO_AW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;

    localparam logic [WB_DW-1:0]   ONE     = WB_DW'(1);
    localparam logic [WB_DW-1:0]   MAX_LEN = WB_DW'(MAX_BURST_LEN);
    localparam logic [WB_DW-1:0]   DEPTH_W = WB_DW'(DEPTH);
    localparam logic [FIFO_AW:0]   DEPTH_F = (FIFO_AW + 1)'(DEPTH);

    logic               circular, irq_en, done, err_flag;
    logic [WB_AW-1:0]   start_addr, base_addr, cur_addr;
    logic [WB_DW-1:0]   buf_size, burst_size, burst_lat;
    logic [WB_DW-1:0]   total, remaining, beats_left, len_full, buf_words;
    logic [31:0]        word_count;
    logic [1:0]         state;

    logic [WB_DW-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   fifo_count, fifo_free;

    logic               cfg_req, cfg_hit, cfg_wr, busy, start_ok, push, pop;
    logic [2:0]         reg_sel;
    logic [WB_DW-1:0]   wmask, rdata;

    function automatic logic [WB_DW-1:0] merge(input logic [WB_DW-1:0] old_v,
                                               input logic [WB_DW-1:0] new_v,
                                               input logic [WB_DW-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign cfg_req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign cfg_hit   = ((wbs_adr_i >> 5) == '0) && (wbs_adr_i[1:0] == 2'b00);
    assign reg_sel   = wbs_adr_i[4:2];
    assign cfg_wr    = cfg_req & wbs_we_i & cfg_hit;
    assign busy      = (state != S_IDLE);
    assign buf_words = buf_size >> WSB_LG;
    assign start_ok  = cfg_wr && (reg_sel == 3'd0) && wbs_sel_i[0] && wbs_dat_i[0]
                       && !busy && (buf_words != '0);
    assign wbs_err_o = 1'b0;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < WSB; i++) wmask[i*8 +: 8] = {8{wbs_sel_i[i]}};
    end

    always_comb begin
        rdata = '0;
        if (cfg_hit) begin
            case (reg_sel)
                3'd0: begin rdata[1] = circular; rdata[2] = irq_en; end
                3'd1: rdata = WB_DW'(start_addr);
                3'd2: rdata = buf_size;
                3'd3: rdata = burst_size;
                3'd4: begin rdata[0] = busy; rdata[1] = done; rdata[2] = err_flag; end
                3'd5: rdata = WB_DW'(word_count);
                default: rdata = '0;
            endcase
        end
    end

    // Next burst length: requested size clamped by bus limit, FIFO depth and what is left.
    always_comb begin
        len_full = (burst_lat == '0) ? ONE : burst_lat;
        if (len_full > MAX_LEN)   len_full = MAX_LEN;
        if (len_full > DEPTH_W)   len_full = DEPTH_W;
        if (len_full > remaining) len_full = remaining;
    end

    assign fifo_free = DEPTH_F - fifo_count;
    assign push      = (state == S_BURST) & wbm_ack_i & ~wbm_err_i;
    assign pop       = stream_m_valid_o & stream_m_ready_i;

    assign wbm_cyc_o = (state == S_BURST);
    assign wbm_stb_o = (state == S_BURST);
    assign wbm_sel_o = {WSB{state == S_BURST}};
    assign wbm_adr_o = cur_addr;
    assign wbm_bte_o = 2'b00;
    assign wbm_cti_o = (state != S_BURST) ? 3'b000 :
                       (beats_left == ONE) ? 3'b111 : 3'b010;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            circular   <= 1'b0;
            irq_en     <= 1'b0;
            done       <= 1'b0;
            err_flag   <= 1'b0;
            start_addr <= '0;
            base_addr  <= '0;
            cur_addr   <= '0;
            buf_size   <= '0;
            burst_size <= '0;
            burst_lat  <= '0;
            total      <= '0;
            remaining  <= '0;
            beats_left <= '0;
            word_count <= '0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            irq_o      <= 1'b0;
        end else begin
            wbs_ack_o <= cfg_req;
            wbs_dat_o <= cfg_req ? rdata : '0;
            irq_o     <= irq_en & (done | err_flag);

            if (cfg_wr) begin
                case (reg_sel)
                    3'd0: if (wbs_sel_i[0]) begin
                        circular <= wbs_dat_i[1];
                        irq_en   <= wbs_dat_i[2];
                    end
                    3'd1: start_addr <= WB_AW'(merge(WB_DW'(start_addr), wbs_dat_i, wmask));
                    3'd2: buf_size   <= merge(buf_size, wbs_dat_i, wmask);
                    3'd3: burst_size <= merge(burst_size, wbs_dat_i, wmask);
                    3'd4: if (wbs_sel_i[0]) begin
                        if (wbs_dat_i[1]) done     <= 1'b0;
                        if (wbs_dat_i[2]) err_flag <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (start_ok)  word_count <= '0;
            else if (pop)  word_count <= word_count + 32'd1;

            // Flag set below follows the W1C above so a same-cycle event is not lost.
            case (state)
                S_IDLE: if (start_ok) begin
                    base_addr <= start_addr;
                    cur_addr  <= start_addr;
                    total     <= buf_words;
                    remaining <= buf_words;
                    burst_lat <= burst_size;
                    state     <= S_WAIT;
                end
                S_WAIT: if ({{(WB_DW-FIFO_AW-1){1'b0}}, fifo_free} >= len_full) begin
                    beats_left <= len_full;
                    state      <= S_BURST;
                end
                S_BURST: begin
                    if (wbm_err_i) begin
                        err_flag <= 1'b1;
                        state    <= S_IDLE;
                    end else if (wbm_ack_i) begin
                        cur_addr   <= cur_addr + WB_AW'(WSB);
                        remaining  <= remaining - ONE;
                        beats_left <= beats_left - ONE;
                        if (beats_left == ONE) begin
                            if (remaining != ONE) begin
                                state <= S_WAIT;
                            end else if (circular) begin
                                cur_addr  <= base_addr;
                                remaining <= total;
                                state     <= S_WAIT;
                            end else begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wbm_dat_i;
    end

    assign stream_m_valid_o = (fifo_count != '0);
    assign stream_m_data_o  = stream_m_valid_o ? mem[rd_ptr] : '0;

endmodule
